// File: rtl/piso_serializer.sv
// piso_serializer: LSB-first parallel-in serial-out with one-word holding buffer
// ports: in_val/in_rdy/in_data word handshake; en shift strobe; shift_out/out_val serial bit;
//        frame_start on first bit, frame_done pulse after last bit; busy while any word held;
//        rst is asynchronous active-low
module piso_serializer #(
  parameter int nbits = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [nbits-1:0] in_data,
  input  logic             en,
  output logic             shift_out,
  output logic             out_val,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);
  localparam int cw = $clog2(nbits);
  localparam logic [cw-1:0] last_idx = cw'(nbits - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [nbits-1:0] sreg, hbuf;
  logic hfull;
  logic [cw-1:0] cnt;
  logic accept, consume, last;
  assign in_rdy = !hfull;
  assign out_val = state == SHIFT;
  assign shift_out = sreg[0];
  assign frame_start = out_val && cnt == '0;
  assign busy = out_val || hfull;
  assign accept = in_val && in_rdy;
  assign consume = out_val && en;
  assign last = consume && cnt == last_idx;
  always_comb begin
    state_n = state == IDLE ? (accept ? SHIFT : IDLE) : ((last && !hfull && !accept) ? IDLE : SHIFT);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
      hbuf <= '0;
      hfull <= 1'b0;
      cnt <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last;
      if (state == IDLE) begin
        if (accept) begin
          sreg <= in_data;
          cnt <= '0;
        end
      end else if (consume) begin
        if (last) begin
          cnt <= '0;
          sreg <= hfull ? hbuf : (accept ? in_data : '0);
          hfull <= 1'b0;
        end else begin
          sreg <= sreg >> 1;
          cnt <= cnt + 1'b1;
        end
      end
      // last-bit accept bypasses hbuf; hfull=1 blocks accept, so set and clear never collide
      if (state == SHIFT && accept && !last) begin
        hbuf <= in_data;
        hfull <= 1'b1;
      end
    end
  end
endmodule
